// File: rtl/tff_toggle_decoder.sv
// rtl/tff_toggle_decoder.sv - recovers t pulses from a tff q level and reports toggles per window
// Optional define TFF_DEC_SYNC_EN: q_in passes a 2-flop synchroniser before decode.
module tff_toggle_decoder #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             q_in,
    output logic             t_rec,
    output logic             q_rec,
    output logic [CNT_W-1:0] count_out,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             sat,
    output logic             overrun
);
    localparam int               WIN_W    = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    logic             q_s;
    logic             q_prev;
    logic [CNT_W-1:0] evt_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic             edge_det;
    logic             at_max;
    logic [CNT_W-1:0] evt_next;
    logic             win_end;
    state_t           state;

`ifdef TFF_DEC_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= q_in;
            sync_q2 <= sync_q1;
        end
    end

    assign q_s = sync_q2;
`else
    assign q_s = q_in;
`endif

    // Decode runs regardless of en so re-enabling never sees a stale level.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_prev <= 1'b0;
            t_rec  <= 1'b0;
            q_rec  <= 1'b0;
        end else begin
            q_prev <= q_s;
            t_rec  <= q_s ^ q_prev;
            q_rec  <= q_s;
        end
    end

    assign edge_det = q_s ^ q_prev;
    assign at_max   = (evt_cnt == CNT_MAX);
    assign evt_next = (edge_det && !at_max) ? evt_cnt + CNT_W'(1) : evt_cnt;
    assign win_end  = en && (win_cnt == WIN_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_cnt <= '0;
            win_cnt <= '0;
            sat     <= 1'b0;
        end else if (en) begin
            if (edge_det && at_max) begin
                sat <= 1'b1;
            end
            if (win_end) begin
                win_cnt <= '0;
                evt_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                evt_cnt <= evt_next;
            end
        end
    end

    // evt_next already folds in this cycle's edge, so it is the window snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            count_out <= '0;
            cnt_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (win_end) begin
                        count_out <= evt_next;
                        cnt_valid <= 1'b1;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    if (win_end) begin
                        if (cnt_ready) begin
                            count_out <= evt_next;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (cnt_ready) begin
                        cnt_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    cnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tff_toggle_decoder.sv
// tb/tb_tff_toggle_decoder.sv - scoreboard bench for tff_toggle_decoder
module tb_tff_toggle_decoder;
    localparam int CNT_W  = 8;
    localparam int WINDOW = 16;
    localparam int SAT_W  = 3;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             q_in;
    logic             cnt_ready;
    logic             t_rec, q_rec, cnt_valid, sat, overrun;
    logic [CNT_W-1:0] count_out;
    logic             t_rec_s, q_rec_s, cnt_valid_s, sat_s, overrun_s;
    logic [SAT_W-1:0] count_out_s;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int got[$];

    bit m_s1, m_s2, m_qprev, m_t_rec, m_q_rec, m_full, m_sat, m_ovr;
    int m_evt, m_win;

    always #5 clk = ~clk;

    tff_toggle_decoder #(.CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
        .clk(clk), .reset(reset), .en(en), .q_in(q_in),
        .t_rec(t_rec), .q_rec(q_rec), .count_out(count_out),
        .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
        .sat(sat), .overrun(overrun)
    );

    tff_toggle_decoder #(.CNT_W(SAT_W), .WINDOW(WINDOW)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .q_in(q_in),
        .t_rec(t_rec_s), .q_rec(q_rec_s), .count_out(count_out_s),
        .cnt_valid(cnt_valid_s), .cnt_ready(cnt_ready),
        .sat(sat_s), .overrun(overrun_s)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference behaviour of the wide instance, advanced once per clock edge.
    task automatic model_update();
        bit qs;
        bit edg;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_qprev = 0; m_t_rec = 0; m_q_rec = 0;
            m_full = 0; m_sat = 0; m_ovr = 0; m_evt = 0; m_win = 0;
            exp_q.delete();
            return;
        end
`ifdef TFF_DEC_SYNC_EN
        qs = m_s2; m_s2 = m_s1; m_s1 = q_in;
`else
        qs = q_in;
`endif
        edg = qs ^ m_qprev;
        m_qprev = qs;
        m_t_rec = edg;
        m_q_rec = qs;
        if (en) begin
            if (edg) begin
                if (m_evt == MAXV) m_sat = 1;
                else m_evt++;
            end
            m_win++;
            if (m_win == WINDOW) begin
                if (!m_full || cnt_ready) begin
                    exp_q.push_back(m_evt);
                    m_full = 1;
                end else begin
                    m_ovr = 1;
                end
                m_evt = 0;
                m_win = 0;
            end else if (m_full && cnt_ready) begin
                m_full = 0;
            end
        end else if (m_full && cnt_ready) begin
            m_full = 0;
        end
    endtask

    task automatic step();
        int e;
        if (!reset && cnt_valid && cnt_ready) begin
            got.push_back(int'(count_out));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count_out", count_out, e);
            end
        end
        @(posedge clk);
        model_update();
        #1;
        check("t_rec", t_rec, m_t_rec);
        check("q_rec", q_rec, m_q_rec);
        check("cnt_valid", cnt_valid, m_full);
        check("sat", sat, m_sat);
        check("overrun", overrun, m_ovr);
    endtask

    task automatic do_reset(input bit lvl);
        reset = 1'b1;
        q_in  = lvl;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        bit lvl;

        reset = 1'b1; en = 1'b1; q_in = 1'b1; cnt_ready = 1'b1;
        repeat (3) step();
        check("rst_count_out", count_out, 0);
        check("rst_count_out_s", count_out_s, 0);
        check("rst_sat_s", sat_s, 0);
        reset = 1'b0; q_in = 1'b0;
        repeat (4) step();
        check("release_t_rec", t_rec, 0);

        // Toggle every 2 cycles: 8 toggles per window.
        do_reset(1'b0); got.delete(); pulses = 0;
        for (int i = 0; i < 64; i++) begin
            q_in = !i[1];
            step();
            pulses += int'(t_rec);
        end
        check("tog_pulses", pulses, 32);
        check("tog_windows", got.size(), 3);
        foreach (got[k]) check("tog_cnt", got[k], 8);

        // Constant high level from reset release.
        do_reset(1'b1); got.delete();
        q_in = 1'b1;
        repeat (49) step();
        check("const_windows", got.size(), 3);
        if (got.size() == 3) begin
            check("const_first", got[0], 1);
            check("const_second", got[1], 0);
            check("const_third", got[2], 0);
        end
        check("const_sat", sat, 0);

        // Backpressure: second snapshot dropped while the first is held.
        do_reset(1'b0); got.delete(); cnt_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            q_in = !i[1];
            step();
            if (i >= 15) begin
                check("bp_hold", count_out, 8);
                check("bp_valid", cnt_valid, 1);
            end
        end
        check("bp_overrun", overrun, 1);
        cnt_ready = 1'b1;
        q_in = 1'b1;
        step();
        check("bp_xfer_cnt", got.size() > 0 ? got[$] : -1, 8);
        check("bp_drained", cnt_valid, 0);
        check("bp_overrun_sticky", overrun, 1);

        // Saturation on the narrow instance.
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) begin
            q_in = !i[0];
            step();
            check("sat_t_rec_s", t_rec_s, t_rec);
            check("sat_q_rec_s", q_rec_s, q_rec);
        end
        check("sat_cnt_s", count_out_s, 7);
        check("sat_valid_s", cnt_valid_s, 1);
        check("sat_flag_s", sat_s, 1);
        check("sat_wide_cnt", count_out, 16);
        check("sat_overrun_s", overrun_s, 0);
        q_in = 1'b0;
        repeat (32) step();
        check("sat_sticky_s", sat_s, 1);
        check("sat_quiet_cnt_s", count_out_s, 0);

        // en low mid-window extends the window and hides two toggles.
        do_reset(1'b0); lvl = 1'b0; pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) lvl = !lvl;
            q_in = lvl;
            step();
        end
        en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j == 0 || j == 3) lvl = !lvl;
            q_in = lvl;
            step();
            pulses += int'(t_rec);
        end
        check("en0_pulses", pulses, 2);
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) lvl = !lvl;
            q_in = lvl;
            step();
            if (k == 6) check("ext_not_yet", cnt_valid, 0);
        end
        check("ext_valid", cnt_valid, 1);
        check("ext_cnt", count_out, 8);

        // Reset at win_cnt=9 restarts the window.
        do_reset(1'b0);
        for (int i = 0; i < 9; i++) begin
            q_in = !i[1];
            step();
        end
        do_reset(1'b0); got.delete();
        for (int i = 0; i < 17; i++) begin
            q_in = i[2];
            step();
        end
        check("rst_mid_windows", got.size(), 1);
        check("rst_mid_cnt", got.size() > 0 ? got[0] : -1, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
